// File: rtl/tv_stream_sequencer.sv
// Streams one Dilithium operation's operands from the test-vector RAM into the core's
// valid/ready input port, walking the fixed per-mode segment list.

module tv_stream_sequencer #(
    parameter int SEC_LEVEL    = 2,
    parameter int W            = 32,
    parameter int MSG_LEN_SIZE = 15,
    parameter int ADDR_W       = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [1:0]              mode,
    input  logic [MSG_LEN_SIZE-1:0] msg_len,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    mem_rd_en,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic [W-1:0]            mem_rd_data,
    output logic [W-1:0]            dout,
    output logic                    dout_valid,
    output logic                    dout_last,
    input  logic                    dout_ready
);

    function automatic int ceilWords(input int bits);
        return (bits + W - 1) / W;
    endfunction

    localparam int K        = (SEC_LEVEL == 2) ? 4 : (SEC_LEVEL == 3) ? 6 : 8;
    localparam int L        = (SEC_LEVEL == 2) ? 4 : (SEC_LEVEL == 3) ? 5 : 7;
    localparam int ETA_BITS = (SEC_LEVEL == 3) ? 4 : 3;
    localparam int Z_BITS   = (SEC_LEVEL == 2) ? 18 : 20;
    localparam int OMEGA    = (SEC_LEVEL == 2) ? 80 : (SEC_LEVEL == 3) ? 55 : 75;
    localparam int WLOG     = $clog2(W);

    localparam int SEED_WORDS = ceilWords(256);
    localparam int S1_WORDS   = ceilWords(L * 256 * ETA_BITS);
    localparam int S2_WORDS   = ceilWords(K * 256 * ETA_BITS);
    localparam int T0_WORDS   = ceilWords(K * 256 * 13);
    localparam int T1_WORDS   = ceilWords(K * 256 * 10);
    localparam int Z_WORDS    = ceilWords(L * 256 * Z_BITS);
    localparam int H_WORDS    = ceilWords((OMEGA + K) * 8);

    localparam logic [1:0] MODE_KEYGEN = 2'b00;
    localparam logic [1:0] MODE_SIGN   = 2'b10;
    localparam logic [1:0] MODE_VERIFY = 2'b01;
    localparam logic [1:0] MODE_BAD    = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_LEN, S_FETCH, S_FLUSH} state_t;

    // RAM segments only; the LEN word is generated internally and is not in this list.
    function automatic logic [15:0] segWords(input logic [1:0] m, input logic [2:0] idx,
                                             input logic [15:0] msgW);
        logic [15:0] n;
        n = 16'd0;
        case (m)
            MODE_SIGN: begin
                case (idx)
                    3'd0, 3'd1, 3'd2: n = 16'(SEED_WORDS);
                    3'd3:             n = 16'(S1_WORDS);
                    3'd4:             n = 16'(S2_WORDS);
                    3'd5:             n = 16'(T0_WORDS);
                    3'd6:             n = msgW;
                    default:          n = 16'd0;
                endcase
            end
            MODE_VERIFY: begin
                case (idx)
                    3'd0, 3'd2: n = 16'(SEED_WORDS);
                    3'd1:       n = 16'(T1_WORDS);
                    3'd3:       n = 16'(Z_WORDS);
                    3'd4:       n = 16'(H_WORDS);
                    3'd5:       n = msgW;
                    default:    n = 16'd0;
                endcase
            end
            default: n = (idx == 3'd0) ? 16'(SEED_WORDS) : 16'd0;
        endcase
        return n;
    endfunction

    state_t                  r_state;
    logic [1:0]              r_mode;
    logic [MSG_LEN_SIZE-1:0] r_msgLen;
    logic [15:0]             r_msgWords;
    logic [2:0]              r_nSeg;
    logic [2:0]              r_segIdx;
    logic [15:0]             r_segLeft;
    logic [ADDR_W-1:0]       r_addr;
    logic                    r_pend;
    logic                    r_pendLast;
    logic [W-1:0]            r_fifoData [3];
    logic                    r_fifoLast [3];
    logic [1:0]              r_count;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_err;

    logic [15:0] w_msgWords;
    logic [2:0]  w_nSeg;
    logic        w_pop;
    logic        w_issue;
    logic        w_lenPush;
    logic        w_push;
    logic [W-1:0] w_pushData;
    logic        w_pushLast;
    logic        w_lastWord;
    logic [15:0] w_nextSegWords;
    logic [1:0]  w_wrIdx;

    assign w_msgWords = 16'((32'(msg_len) + 32'(W - 1)) >> WLOG);

    // An empty message drops the trailing MSG segment from the walk entirely.
    always_comb begin
        w_nSeg = 3'd1;
        case (mode)
            MODE_SIGN:   w_nSeg = (w_msgWords == 16'd0) ? 3'd6 : 3'd7;
            MODE_VERIFY: w_nSeg = (w_msgWords == 16'd0) ? 3'd5 : 3'd6;
            default:     w_nSeg = 3'd1;
        endcase
    end

    assign dout       = r_fifoData[0];
    assign dout_last  = r_fifoLast[0];
    assign dout_valid = (r_count != 2'd0);
    assign w_pop      = dout_valid & dout_ready;

    // Reads already in flight reserve FIFO slots, so the 3-entry buffer can never overflow.
    assign w_issue    = (r_state == S_FETCH) && (({1'b0, r_count} + {2'b0, r_pend}) <= 3'd2);
    assign w_lenPush  = (r_state == S_LEN);
    assign w_push     = w_lenPush | r_pend;
    assign w_pushData = w_lenPush ? W'(r_msgLen) : mem_rd_data;
    assign w_pushLast = w_lenPush ? 1'b0 : r_pendLast;
    assign w_wrIdx    = r_count - {1'b0, w_pop};

    assign w_lastWord     = (r_segLeft == 16'd1) && (r_segIdx == r_nSeg - 3'd1);
    assign w_nextSegWords = segWords(r_mode, r_segIdx + 3'd1, r_msgWords);

    assign mem_rd_en = w_issue;
    assign mem_addr  = r_addr;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_mode     <= MODE_KEYGEN;
            r_msgLen   <= '0;
            r_msgWords <= 16'd0;
            r_nSeg     <= 3'd0;
            r_segIdx   <= 3'd0;
            r_segLeft  <= 16'd0;
            r_addr     <= '0;
            r_pend     <= 1'b0;
            r_pendLast <= 1'b0;
            r_count    <= 2'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                r_fifoData[i] <= '0;
                r_fifoLast[i] <= 1'b0;
            end
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;

            if (w_pop) begin
                r_fifoData[0] <= r_fifoData[1];
                r_fifoData[1] <= r_fifoData[2];
                r_fifoLast[0] <= r_fifoLast[1];
                r_fifoLast[1] <= r_fifoLast[2];
            end
            if (w_push) begin
                r_fifoData[w_wrIdx] <= w_pushData;
                r_fifoLast[w_wrIdx] <= w_pushLast;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};

            r_pend <= w_issue;
            if (w_issue) begin
                r_pendLast <= w_lastWord;
                r_addr     <= r_addr + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (mode == MODE_BAD) begin
                            r_err <= 1'b1;
                        end else begin
                            r_mode     <= mode;
                            r_msgLen   <= msg_len;
                            r_msgWords <= w_msgWords;
                            r_nSeg     <= w_nSeg;
                            r_segIdx   <= 3'd0;
                            r_segLeft  <= segWords(mode, 3'd0, w_msgWords);
                            r_addr     <= '0;
                            r_busy     <= 1'b1;
                            r_state    <= (mode == MODE_KEYGEN) ? S_FETCH : S_LEN;
                        end
                    end
                end
                S_LEN: r_state <= S_FETCH;
                S_FETCH: begin
                    if (w_issue) begin
                        if (w_lastWord) begin
                            r_state <= S_FLUSH;
                        end else if (r_segLeft == 16'd1) begin
                            r_segIdx  <= r_segIdx + 3'd1;
                            r_segLeft <= w_nextSegWords;
                        end else begin
                            r_segLeft <= r_segLeft - 16'd1;
                        end
                    end
                end
                S_FLUSH: begin
                    if (w_pop && dout_last) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tv_stream_sequencer.sv
// Directed bench for tv_stream_sequencer: one L2 and one L3 instance, RAM model returns
// its own word address, handshakes are logged on the falling edge and checked afterwards.

module tb_tv_stream_sequencer;

    localparam int W   = 32;
    localparam int AW  = 12;
    localparam int MLS = 15;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        int          cycle;
    } hs_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start2 = 1'b0;
    logic           start3 = 1'b0;
    logic [1:0]     mode = 2'b00;
    logic [MLS-1:0] msg_len = '0;
    logic           dout_ready = 1'b1;

    logic          busy2, done2, err2, rdEn2, valid2, last2;
    logic [AW-1:0] addr2;
    logic [W-1:0]  rdData2, dout2;
    logic          busy3, done3, err3, rdEn3, valid3, last3;
    logic [AW-1:0] addr3;
    logic [W-1:0]  rdData3, dout3;

    int cyc = 0;
    int startCyc = 0;
    int checks = 0;
    int errors = 0;

    hs_t q2[$];
    hs_t q3[$];
    hs_t hs2, hs3;
    int reads2 = 0, reads3 = 0, stallBad2 = 0, stallBad3 = 0;
    logic prevStall2 = 1'b0, prevStall3 = 1'b0, prevLast2 = 1'b0, prevLast3 = 1'b0;
    logic [W-1:0] prevData2 = '0, prevData3 = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tv_stream_sequencer #(.SEC_LEVEL(2), .W(W), .MSG_LEN_SIZE(MLS), .ADDR_W(AW)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode), .msg_len(msg_len),
        .busy(busy2), .done(done2), .err(err2), .mem_rd_en(rdEn2), .mem_addr(addr2),
        .mem_rd_data(rdData2), .dout(dout2), .dout_valid(valid2), .dout_last(last2),
        .dout_ready(dout_ready));

    tv_stream_sequencer #(.SEC_LEVEL(3), .W(W), .MSG_LEN_SIZE(MLS), .ADDR_W(AW)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .mode(mode), .msg_len(msg_len),
        .busy(busy3), .done(done3), .err(err3), .mem_rd_en(rdEn3), .mem_addr(addr3),
        .mem_rd_data(rdData3), .dout(dout3), .dout_valid(valid3), .dout_last(last3),
        .dout_ready(dout_ready));

    always @(posedge clk) if (rdEn2) rdData2 <= 32'(addr2);
    always @(posedge clk) if (rdEn3) rdData3 <= 32'(addr3);

    // Inputs change just after the rising edge, so the falling edge sees the handshake inputs.
    always @(negedge clk) begin
        if (!rst_n) begin
            prevStall2 = 1'b0;
        end else begin
            if (rdEn2) reads2++;
            if (prevStall2 && (!valid2 || dout2 !== prevData2 || last2 !== prevLast2)) stallBad2++;
            if (valid2 && dout_ready) begin
                hs2.data = dout2; hs2.last = last2; hs2.cycle = cyc;
                q2.push_back(hs2);
            end
            prevStall2 = valid2 && !dout_ready;
            prevData2 = dout2;
            prevLast2 = last2;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prevStall3 = 1'b0;
        end else begin
            if (rdEn3) reads3++;
            if (prevStall3 && (!valid3 || dout3 !== prevData3 || last3 !== prevLast3)) stallBad3++;
            if (valid3 && dout_ready) begin
                hs3.data = dout3; hs3.last = last3; hs3.cycle = cyc;
                q3.push_back(hs3);
            end
            prevStall3 = valid3 && !dout_ready;
            prevData3 = dout3;
            prevLast3 = last3;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s2, input logic s3, input logic [1:0] m,
                                 input logic [MLS-1:0] len);
        nextCycle();
        start2 = s2;
        start3 = s3;
        mode = m;
        msg_len = len;
        startCyc = cyc;
    endtask

    task automatic waitDone(input int sel, input int maxCycles, output int rel, output logic busyAt);
        rel = -1;
        busyAt = 1'b1;
        for (int i = 0; i < maxCycles; i++) begin
            nextCycle();
            start2 = 1'b0;
            start3 = 1'b0;
            if ((sel == 2) ? done2 : done3) begin
                rel = cyc - startCyc;
                busyAt = (sel == 2) ? busy2 : busy3;
                break;
            end
        end
    endtask

    function automatic hs_t getHs(input int sel, input int idx);
        if (sel == 2) return q2[idx];
        return q3[idx];
    endfunction

    // RAM word j carries value j; firstRel < 0 skips the no-gap timing check.
    task automatic checkStream(input string tag, input int sel, input int base, input bit hasLen,
                               input logic [31:0] lenVal, input int nRam, input int firstRel);
        int n, bad, off;
        hs_t e;
        n = (sel == 2) ? q2.size() : q3.size();
        checkOutput({tag, "_count"}, 64'(n - base), 64'(nRam + int'(hasLen)));
        bad = 0;
        off = hasLen ? 1 : 0;
        if (hasLen) begin
            e = getHs(sel, base);
            if (n <= base || e.data !== lenVal || e.last !== 1'b0) bad++;
        end
        for (int j = 0; j < nRam; j++) begin
            if (base + off + j >= n) begin
                bad++;
                break;
            end
            e = getHs(sel, base + off + j);
            if (e.data !== 32'(j) || e.last !== (j == nRam - 1)) bad++;
            if (firstRel >= 0 && (e.cycle - startCyc) != firstRel + j) bad++;
        end
        checkOutput({tag, "_words"}, 64'(bad), 64'd0);
    endtask

    initial begin
        int base, rb, sb, rel;
        logic busyAt;

        $display("[TB] reset");
        repeat (3) nextCycle();
        rst_n = 1'b1;
        checkOutput("reset_ctl2", {busy2, done2, err2, rdEn2, valid2, last2}, 64'd0);
        checkOutput("reset_addr2", 64'(addr2), 64'd0);
        checkOutput("reset_dout2", 64'(dout2), 64'd0);
        checkOutput("reset_ctl3", {busy3, done3, err3, rdEn3, valid3, last3, addr3, dout3}, 64'd0);

        $display("[TB] keygen L2");
        base = q2.size(); rb = reads2;
        applyStimulus(1'b1, 1'b0, 2'b00, '0);
        checkOutput("kg_busy_c0", 64'(busy2), 64'd0);
        nextCycle(); start2 = 1'b0;
        checkOutput("kg_c1", {busy2, rdEn2, 4'(addr2)}, {1'b1, 1'b1, 4'd0});
        nextCycle();
        checkOutput("kg_valid_c2", 64'(valid2), 64'd0);
        nextCycle();
        checkOutput("kg_c3", {valid2, dout2}, {1'b1, 32'd0});
        waitDone(2, 100, rel, busyAt);
        checkOutput("kg_done_cycle", 64'(rel), 64'd11);
        checkOutput("kg_busy_at_done", 64'(busyAt), 64'd0);
        checkStream("kg", 2, base, 1'b0, 32'd0, 8, 3);
        checkOutput("kg_reads", 64'(reads2 - rb), 64'd8);
        nextCycle();
        checkOutput("kg_done_pulse", 64'(done2), 64'd0);

        $display("[TB] sign L2 msg_len=64");
        base = q2.size(); rb = reads2;
        applyStimulus(1'b1, 1'b0, 2'b10, 15'd64);
        nextCycle(); start2 = 1'b0;
        checkOutput("sg_c1", {busy2, rdEn2, valid2}, {1'b1, 1'b0, 1'b0});
        nextCycle();
        checkOutput("sg_c2", {valid2, dout2, rdEn2, addr2}, {1'b1, 32'h40, 1'b1, 12'd0});
        waitDone(2, 2000, rel, busyAt);
        checkOutput("sg_done_cycle", 64'(rel), 64'd638);
        checkStream("sg", 2, base, 1'b1, 32'h40, 634, 4);
        checkOutput("sg_reads", 64'(reads2 - rb), 64'd634);

        $display("[TB] sign L2 random ready with ignored start");
        base = q2.size(); sb = stallBad2;
        applyStimulus(1'b1, 1'b0, 2'b10, 15'd64);
        rel = -1;
        for (int i = 0; i < 4000; i++) begin
            nextCycle();
            if (done2) begin
                rel = cyc - startCyc;
                break;
            end
            dout_ready = 1'($urandom_range(0, 1));
            start2 = (i == 40);
            mode = (i == 40) ? 2'b00 : 2'b10;
        end
        start2 = 1'b0;
        dout_ready = 1'b1;
        checkOutput("rnd_done_seen", 64'(rel >= 0), 64'd1);
        checkStream("rnd", 2, base, 1'b1, 32'h40, 634, -1);
        checkOutput("rnd_stall_stable", 64'(stallBad2 - sb), 64'd0);

        $display("[TB] mode 11");
        rb = reads2;
        applyStimulus(1'b1, 1'b0, 2'b11, '0);
        nextCycle(); start2 = 1'b0;
        checkOutput("bad_c1", {err2, busy2, rdEn2}, {1'b1, 1'b0, 1'b0});
        nextCycle();
        checkOutput("bad_c2", {err2, busy2}, {1'b0, 1'b0});
        checkOutput("bad_reads", 64'(reads2 - rb), 64'd0);

        $display("[TB] verify L3 msg_len=0");
        base = q3.size(); rb = reads3;
        applyStimulus(1'b0, 1'b1, 2'b01, '0);
        waitDone(3, 3000, rel, busyAt);
        checkOutput("vf_done_cycle", 64'(rel), 64'd1316);
        checkStream("vf", 3, base, 1'b1, 32'd0, 1312, 4);
        checkOutput("vf_reads", 64'(reads3 - rb), 64'd1312);

        $display("[TB] reset mid-Z then verify L3 msg_len=16");
        applyStimulus(1'b0, 1'b1, 2'b01, 15'd16);
        for (int i = 0; i < 2000; i++) begin
            nextCycle();
            start3 = 1'b0;
            if (addr3 >= 12'd600) break;
        end
        checkOutput("midz_reached", 64'(addr3 >= 12'd600 && addr3 < 12'd1296), 64'd1);
        rst_n = 1'b0;
        nextCycle();
        rst_n = 1'b1;
        checkOutput("midz_reset_ctl", {busy3, done3, err3, rdEn3, valid3, last3}, 64'd0);
        checkOutput("midz_reset_data", {addr3, dout3}, 64'd0);
        base = q3.size(); rb = reads3;
        applyStimulus(1'b0, 1'b1, 2'b01, 15'd16);
        waitDone(3, 3000, rel, busyAt);
        checkOutput("rv_done_cycle", 64'(rel), 64'd1317);
        checkStream("rv", 3, base, 1'b1, 32'd16, 1313, 4);
        checkOutput("rv_reads", 64'(reads3 - rb), 64'd1313);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
